capture_buffer_mc_axi: RTL

- Multi-channel successor to the single-channel capture buffer. Each channel latches one sample per rising edge of its strobe into its own on-chip memory.
- Stored samples are readable over AXI4-Lite.
- On request, the block streams a selected channel out over a valid/ready port in oldest-first order.
- Adds parametrised width, depth and channel count, one-shot or ring mode, overflow flags, clear, and correct AXI handshakes.

---
 rtl/capture_buffer_mc_axi.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/capture_buffer_mc_axi.sv
// Multi-channel strobe-driven sample capture with AXI4-Lite readback/control
// and an oldest-first valid/ready stream of one selected channel.
module capture_buffer_mc_axi #(
    parameter int DATA_WIDTH           = 32,
    parameter int DEPTH                = 2048,
    parameter int NUM_CH               = 2,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 16
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [NUM_CH-1:0]                 in_strobe,
    input  logic [NUM_CH*DATA_WIDTH-1:0]      in_data,
    input  logic                              request_signal,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic                              m_last,
    output logic                              stream_done,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WW  = C_S00_AXI_ADDR_WIDTH - 2;
    localparam int IW  = C_S00_AXI_ADDR_WIDTH - 3;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

    logic [DATA_WIDTH-1:0] r_mem [NUM_CH][DEPTH];
    logic [AW-1:0]         r_wr_ptr [NUM_CH];
    logic [CW-1:0]         r_count [NUM_CH];
    logic [NUM_CH-1:0]     r_ovf, r_strobe_d;
    logic                  r_en, r_ring, r_autoclr, r_clr_all;
    logic [2:0]            r_out_ch;

    state_t                r_state;
    logic [CHW-1:0]        r_ch;
    logic [CW-1:0]         r_n;
    logic [AW-1:0]         r_rd;
    logic                  r_req_d;

    logic                  r_awready, r_bvalid;
    logic                  r_arready, r_rd_busy, r_rd_dec, r_rvalid;
    logic [WW-1:0]         r_ar_idx;
    logic [C_S00_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic [NUM_CH-1:0]     w_full, w_cap, w_clr, w_we;
    logic [CHW-1:0]        w_sel_ch;
    logic                  w_streaming;
    logic [IW-1:0]         w_win_idx, w_win_ch;
    logic [C_S00_AXI_DATA_WIDTH-1:0] w_rd_word;
    logic                  w_rd_err;
    logic                  w_unused;

    assign w_streaming = (r_state != S_IDLE);
    assign w_sel_ch    = (int'(r_out_ch) < NUM_CH) ? r_out_ch[CHW-1:0] : '0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_full = '0;
        w_cap  = '0;
        w_clr  = '0;
        w_we   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_full[c] = (r_count[c] == CW'(DEPTH));
            w_cap[c]  = in_strobe[c] & ~r_strobe_d[c] & r_en;
            w_clr[c]  = r_clr_all | (r_state == S_DONE && r_autoclr && r_ch == CHW'(c));
            w_we[c]   = w_cap[c] & ~w_clr[c] & (~w_full[c] | r_ring);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_strobe_d <= '0;
            r_ovf      <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_wr_ptr[c] <= '0;
                r_count[c]  <= '0;
            end
        end else begin
            r_strobe_d <= in_strobe;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_clr[c]) begin
                    r_wr_ptr[c] <= '0;
                    r_count[c]  <= '0;
                    r_ovf[c]    <= 1'b0;
                end else if (w_cap[c]) begin
                    if (!w_full[c]) begin
                        r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
                        r_count[c]  <= r_count[c] + 1'b1;
                    end else begin
                        r_ovf[c] <= 1'b1;
                        if (r_ring) r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: sample memory has no reset; its contents are meaningless until written.
    always_ff @(posedge s00_axi_aclk) begin
        for (int c = 0; c < NUM_CH; c++)
            if (w_we[c]) r_mem[c][r_wr_ptr[c]] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
    end

    // Stream engine: each beat is one LOAD (memory read) plus one SEND (handshake).
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_state     <= S_IDLE;
            r_req_d     <= 1'b0;
            r_ch        <= '0;
            r_n         <= '0;
            r_rd        <= '0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            stream_done <= 1'b0;
        end else begin
            r_req_d <= request_signal;
            case (r_state)
                S_IDLE: if (request_signal && !r_req_d) begin
                    r_ch <= w_sel_ch;
                    r_n  <= r_count[w_sel_ch];
                    r_rd <= w_full[w_sel_ch] ? r_wr_ptr[w_sel_ch] : '0;
                    if (r_count[w_sel_ch] == '0) begin
                        r_state     <= S_DONE;
                        stream_done <= 1'b1;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    m_data  <= r_mem[r_ch][r_rd];
                    m_valid <= 1'b1;
                    m_last  <= (r_n == CW'(1));
                    r_state <= S_SEND;
                end
                S_SEND: if (m_ready) begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    r_n     <= r_n - 1'b1;
                    r_rd    <= r_rd + 1'b1;
                    if (r_n == CW'(1)) begin
                        r_state     <= S_DONE;
                        stream_done <= 1'b1;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    stream_done <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_en      <= 1'b0;
            r_ring    <= 1'b0;
            r_autoclr <= 1'b0;
            r_out_ch  <= '0;
            r_clr_all <= 1'b0;
        end else begin
            r_clr_all <= 1'b0;
            if (r_bvalid && s00_axi_bready) r_bvalid <= 1'b0;
            if (r_awready) begin
                r_awready <= 1'b0;
                r_bvalid  <= 1'b1;
                if (s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2] == '0) begin
                    if (s00_axi_wstrb[0]) begin
                        r_en      <= s00_axi_wdata[0];
                        r_ring    <= s00_axi_wdata[1];
                        r_clr_all <= s00_axi_wdata[2];
                        r_autoclr <= s00_axi_wdata[3];
                    end
                    if (s00_axi_wstrb[1]) r_out_ch <= s00_axi_wdata[10:8];
                end
            end else if (s00_axi_awvalid && s00_axi_wvalid && !r_bvalid) begin
                r_awready <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        w_rd_err  = 1'b0;
        w_win_idx = r_ar_idx[IW-1:0];
        w_win_ch  = w_win_idx >> AW;
        if (r_ar_idx[WW-1]) begin
            if (w_streaming)
                w_rd_err = 1'b1;
            else if ({1'b0, w_win_idx} < (IW+1)'(NUM_CH*DEPTH))
                w_rd_word[DATA_WIDTH-1:0] = r_mem[w_win_ch[CHW-1:0]][w_win_idx[AW-1:0]];
        end else if (r_ar_idx == WW'(0)) begin
            w_rd_word[0]    = r_en;
            w_rd_word[1]    = r_ring;
            w_rd_word[3]    = r_autoclr;
            w_rd_word[10:8] = r_out_ch;
        end else if (r_ar_idx == WW'(1)) begin
            w_rd_word[NUM_CH-1:0]  = w_full;
            w_rd_word[16 +: NUM_CH] = r_ovf;
            w_rd_word[31]          = w_streaming;
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                if (r_ar_idx == WW'(c + 2)) w_rd_word[CW-1:0] = r_count[c];
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_arready <= 1'b0;
            r_rd_busy <= 1'b0;
            r_rd_dec  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_ar_idx  <= '0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else begin
            if (r_arready) begin
                r_arready <= 1'b0;
                r_ar_idx  <= s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2];
                r_rd_dec  <= 1'b1;
            end else if (s00_axi_arvalid && !r_rd_busy) begin
                r_arready <= 1'b1;
                r_rd_busy <= 1'b1;
            end
            if (r_rd_dec) begin
                r_rd_dec <= 1'b0;
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_word;
                r_rresp  <= w_rd_err ? 2'b10 : 2'b00;
            end
            if (r_rvalid && s00_axi_rready) begin
                r_rvalid  <= 1'b0;
                r_rd_busy <= 1'b0;
            end
        end
    end

    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_awready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = r_rresp;

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                        s00_axi_araddr[1:0], s00_axi_wdata, s00_axi_wstrb, w_win_ch};
endmodule
